// File: rtl/hrm_fifo_bank.sv
// -----------------------------------------------------------------------------
// hrm_fifo_bank
// A bank of NCH independent first-word-fall-through FIFOs that share one push
// port, one pop port and one random-access dump port. Each channel has sticky
// overflow/underflow flags that are cleared together by i_clr_err.
//
// Ports
//   clk          : single clock, all state changes on its rising edge
//   i_rst        : synchronous, active-high reset (empties every channel)
//   i_wr         : push request
//   i_wr_ch      : channel receiving the push
//   i_data       : push data
//   i_rd         : pop request
//   i_rd_ch      : channel popped, and the channel shown on o_data
//   o_data       : head word of channel i_rd_ch (0 when empty or invalid)
//   o_empty_n    : per-channel not-empty flags
//   o_full       : per-channel full flags
//   o_ovf        : per-channel sticky overflow flags
//   o_udf        : per-channel sticky underflow flags
//   i_clr_err    : clears all sticky flags
//   i_dmp_ch     : channel inspected through the dump port
//   i_dmp_pos    : entry offset from the head of i_dmp_ch
//   o_dmp_data   : word at i_dmp_pos (0 when not valid)
//   o_dmp_valid  : i_dmp_pos lies below the fill level of i_dmp_ch
//   o_fill       : fill level of i_dmp_ch (0..DEPTH)
// -----------------------------------------------------------------------------
module hrm_fifo_bank #(
  parameter int NCH    = 2,
  parameter int DW     = 8,
  parameter int LGFLEN = 5,
  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_wr,
  input  logic [CW-1:0]     i_wr_ch,
  input  logic [DW-1:0]     i_data,
  input  logic              i_rd,
  input  logic [CW-1:0]     i_rd_ch,
  output logic [DW-1:0]     o_data,
  output logic [NCH-1:0]    o_empty_n,
  output logic [NCH-1:0]    o_full,
  output logic [NCH-1:0]    o_ovf,
  output logic [NCH-1:0]    o_udf,
  input  logic              i_clr_err,
  input  logic [CW-1:0]     i_dmp_ch,
  input  logic [LGFLEN-1:0] i_dmp_pos,
  output logic [DW-1:0]     o_dmp_data,
  output logic              o_dmp_valid,
  output logic [LGFLEN:0]   o_fill
);

  localparam int DEPTH = 1 << LGFLEN;
  localparam logic [LGFLEN:0] FULL_CNT = (LGFLEN + 1)'(DEPTH);
  localparam logic [LGFLEN:0] CNT_ONE  = {{LGFLEN{1'b0}}, 1'b1};

  logic [DW-1:0]     r_mem    [NCH][DEPTH];
  logic [LGFLEN:0]   r_wr_ptr [NCH];
  logic [LGFLEN:0]   r_rd_ptr [NCH];
  logic [LGFLEN:0]   r_cnt    [NCH];
  logic [NCH-1:0]    r_ovf;
  logic [NCH-1:0]    r_udf;

  logic [NCH-1:0]    w_wr_hit;
  logic [NCH-1:0]    w_rd_hit;
  logic [NCH-1:0]    w_dmp_sel;
  logic [NCH-1:0]    w_full;
  logic [NCH-1:0]    w_empty;
  logic [NCH-1:0]    w_do_push;
  logic [NCH-1:0]    w_do_pop;
  logic [NCH-1:0]    w_ovf_set;
  logic [NCH-1:0]    w_udf_set;
  logic [NCH-1:0]    w_dmp_in;
  logic [LGFLEN-1:0] w_dmp_addr [NCH];

  logic [DW-1:0]     w_data;
  logic [DW-1:0]     w_dmp_data;
  logic              w_dmp_valid;
  logic [LGFLEN:0]   w_fill;

  // Channel decode and per-channel push/pop/error qualification.
  always_comb begin
    w_wr_hit  = '0;
    w_rd_hit  = '0;
    w_dmp_sel = '0;
    w_full    = '0;
    w_empty   = '0;
    w_do_push = '0;
    w_do_pop  = '0;
    w_ovf_set = '0;
    w_udf_set = '0;
    for (int c = 0; c < NCH; c++) begin
      // A select that matches no channel index simply hits nothing.
      w_wr_hit[c]  = i_wr & (i_wr_ch == CW'(c));
      w_rd_hit[c]  = i_rd & (i_rd_ch == CW'(c));
      w_dmp_sel[c] = (i_dmp_ch == CW'(c));
      w_full[c]    = (r_cnt[c] == FULL_CNT);
      w_empty[c]   = (r_cnt[c] == '0);
      // A full channel still accepts a push when the same cycle pops it.
      w_do_push[c] = w_wr_hit[c] & (~w_full[c] | w_rd_hit[c]);
      w_do_pop[c]  = w_rd_hit[c] & ~w_empty[c];
      w_ovf_set[c] = w_wr_hit[c] & w_full[c] & ~w_rd_hit[c];
      // Pop of an empty channel flags underflow even if a push rides along.
      w_udf_set[c] = w_rd_hit[c] & w_empty[c];
    end
  end

  // Pointer and fill-count registers; reset empties every channel at once.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (i_rst) begin
        r_wr_ptr[c] <= '0;
        r_rd_ptr[c] <= '0;
        r_cnt[c]    <= '0;
      end else begin
        if (w_do_push[c]) begin
          r_wr_ptr[c] <= r_wr_ptr[c] + CNT_ONE;
        end
        if (w_do_pop[c]) begin
          r_rd_ptr[c] <= r_rd_ptr[c] + CNT_ONE;
        end
        case ({w_do_push[c], w_do_pop[c]})
          2'b10:   r_cnt[c] <= r_cnt[c] + CNT_ONE;
          2'b01:   r_cnt[c] <= r_cnt[c] - CNT_ONE;
          default: r_cnt[c] <= r_cnt[c];
        endcase
      end
    end
  end

  // Sticky error flags; a new event outranks the clear in the same cycle.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_ovf <= '0;
      r_udf <= '0;
    end else if (i_clr_err) begin
      r_ovf <= w_ovf_set;
      r_udf <= w_udf_set;
    end else begin
      r_ovf <= r_ovf | w_ovf_set;
      r_udf <= r_udf | w_udf_set;
    end
  end

  // Storage array; contents are left untouched by reset.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (!i_rst && w_do_push[c]) begin
        r_mem[c][r_wr_ptr[c][LGFLEN-1:0]] <= i_data;
      end
    end
  end

  // Read-side muxes built as AND-OR so unselected or invalid channels give 0.
  always_comb begin
    w_data      = '0;
    w_dmp_data  = '0;
    w_dmp_valid = 1'b0;
    w_fill      = '0;
    w_dmp_in    = '0;
    for (int c = 0; c < NCH; c++) begin
      w_dmp_addr[c] = r_rd_ptr[c][LGFLEN-1:0] + i_dmp_pos;
      w_dmp_in[c]   = ({1'b0, i_dmp_pos} < r_cnt[c]);
      w_data      = w_data |
                    ({DW{w_rd_sel(c) & ~w_empty[c]}} & r_mem[c][r_rd_ptr[c][LGFLEN-1:0]]);
      w_fill      = w_fill | ({(LGFLEN + 1){w_dmp_sel[c]}} & r_cnt[c]);
      w_dmp_valid = w_dmp_valid | (w_dmp_sel[c] & w_dmp_in[c]);
      w_dmp_data  = w_dmp_data |
                    ({DW{w_dmp_sel[c] & w_dmp_in[c]}} & r_mem[c][w_dmp_addr[c]]);
    end
  end

  function automatic logic w_rd_sel(input int c);
    return (i_rd_ch == CW'(c));
  endfunction

  assign o_data      = w_data;
  assign o_empty_n   = ~w_empty;
  assign o_full      = w_full;
  assign o_ovf       = r_ovf;
  assign o_udf       = r_udf;
  assign o_dmp_data  = w_dmp_data;
  assign o_dmp_valid = w_dmp_valid;
  assign o_fill      = w_fill;

endmodule

// File: tb/tb_hrm_fifo_bank.sv
// -----------------------------------------------------------------------------
// tb_hrm_fifo_bank
// Directed bench for hrm_fifo_bank (NCH=3, DW=8, LGFLEN=5). Stimulus drives
// operations and queues hand-computed expectations; a monitor on the falling
// edge pops each expectation and compares it with the DUT output it names.
// -----------------------------------------------------------------------------
module tb_hrm_fifo_bank;

  localparam int NCH = 3;
  localparam int DW = 8;
  localparam int LG = 5;
  localparam int CW = 2;

  // Which DUT output an expectation refers to.
  localparam logic [3:0] S_DATA = 4'd0;
  localparam logic [3:0] S_ENN  = 4'd1;
  localparam logic [3:0] S_FULL = 4'd2;
  localparam logic [3:0] S_OVF  = 4'd3;
  localparam logic [3:0] S_UDF  = 4'd4;
  localparam logic [3:0] S_FILL = 4'd5;
  localparam logic [3:0] S_DMPD = 4'd6;
  localparam logic [3:0] S_DMPV = 4'd7;

  typedef struct packed {
    logic [3:0]  sig;
    logic [31:0] exp;
  } exp_t;

  logic            clk;
  logic            i_rst;
  logic            i_wr;
  logic [CW-1:0]   i_wr_ch;
  logic [DW-1:0]   i_data;
  logic            i_rd;
  logic [CW-1:0]   i_rd_ch;
  logic [DW-1:0]   o_data;
  logic [NCH-1:0]  o_empty_n;
  logic [NCH-1:0]  o_full;
  logic [NCH-1:0]  o_ovf;
  logic [NCH-1:0]  o_udf;
  logic            i_clr_err;
  logic [CW-1:0]   i_dmp_ch;
  logic [LG-1:0]   i_dmp_pos;
  logic [DW-1:0]   o_dmp_data;
  logic            o_dmp_valid;
  logic [LG:0]     o_fill;

  exp_t  sb_q[$];
  string sb_name[$];
  int    n_vec;
  int    n_err;

  hrm_fifo_bank #(.NCH(NCH), .DW(DW), .LGFLEN(LG)) dut (
    .clk(clk), .i_rst(i_rst), .i_wr(i_wr), .i_wr_ch(i_wr_ch), .i_data(i_data),
    .i_rd(i_rd), .i_rd_ch(i_rd_ch), .o_data(o_data), .o_empty_n(o_empty_n),
    .o_full(o_full), .o_ovf(o_ovf), .o_udf(o_udf), .i_clr_err(i_clr_err),
    .i_dmp_ch(i_dmp_ch), .i_dmp_pos(i_dmp_pos), .o_dmp_data(o_dmp_data),
    .o_dmp_valid(o_dmp_valid), .o_fill(o_fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare every queued expectation against the live outputs.
  always @(negedge clk) begin
    exp_t        it;
    string       nm;
    logic [31:0] act;
    while (sb_q.size() > 0) begin
      it  = sb_q.pop_front();
      nm  = sb_name.pop_front();
      case (it.sig)
        S_DATA:  act = 32'(o_data);
        S_ENN:   act = 32'(o_empty_n);
        S_FULL:  act = 32'(o_full);
        S_OVF:   act = 32'(o_ovf);
        S_UDF:   act = 32'(o_udf);
        S_FILL:  act = 32'(o_fill);
        S_DMPD:  act = 32'(o_dmp_data);
        S_DMPV:  act = 32'(o_dmp_valid);
        default: act = 32'hDEAD_BEEF;
      endcase
      n_vec++;
      if (act !== it.exp) begin
        n_err++;
        $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, it.exp, $time);
      end
    end
  end

  task automatic step(input logic wr, input logic [CW-1:0] wch, input logic [DW-1:0] d,
                      input logic rd, input logic [CW-1:0] rch,
                      input logic clr, input logic rst);
    i_wr = wr; i_wr_ch = wch; i_data = d;
    i_rd = rd; i_rd_ch = rch;
    i_clr_err = clr; i_rst = rst;
    @(posedge clk); #1;
    i_wr = 1'b0; i_rd = 1'b0; i_clr_err = 1'b0; i_rst = 1'b0;
  endtask

  task automatic view(input logic [CW-1:0] rch, input logic [CW-1:0] dch, input logic [LG-1:0] pos);
    i_rd_ch = rch; i_dmp_ch = dch; i_dmp_pos = pos;
  endtask

  task automatic ex(input string nm, input logic [3:0] s, input logic [31:0] v);
    exp_t e;
    e.sig = s;
    e.exp = v;
    sb_q.push_back(e);
    sb_name.push_back(nm);
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    i_rst = 1'b1; i_wr = 1'b0; i_wr_ch = '0; i_data = '0;
    i_rd = 1'b0; i_rd_ch = '0; i_clr_err = 1'b0; i_dmp_ch = '0; i_dmp_pos = '0;
    repeat (2) @(posedge clk);
    #1 i_rst = 1'b0;

    // Reset state
    view(2'd0, 2'd0, 5'd0);
    ex("rst_empty_n", S_ENN, 32'h0); ex("rst_full", S_FULL, 32'h0);
    ex("rst_fill", S_FILL, 32'd0); ex("rst_dmp_valid", S_DMPV, 32'h0);
    ex("rst_data", S_DATA, 32'h0); ex("rst_ovf", S_OVF, 32'h0); ex("rst_udf", S_UDF, 32'h0);
    settle();

    // Three pushes to ch0, then dump inspection
    step(1'b1, 2'd0, 8'h11, 1'b0, 2'd0, 1'b0, 1'b0);
    step(1'b1, 2'd0, 8'h22, 1'b0, 2'd0, 1'b0, 1'b0);
    step(1'b1, 2'd0, 8'h33, 1'b0, 2'd0, 1'b0, 1'b0);
    view(2'd0, 2'd0, 5'd2);
    ex("c0_fill3", S_FILL, 32'd3); ex("c0_head", S_DATA, 32'h11);
    ex("c0_empty_n", S_ENN, 32'b001);
    ex("c0_dmp2_data", S_DMPD, 32'h33); ex("c0_dmp2_valid", S_DMPV, 32'h1);
    settle();
    view(2'd0, 2'd0, 5'd3);
    ex("c0_dmp3_valid", S_DMPV, 32'h0); ex("c0_dmp3_data", S_DMPD, 32'h0);
    settle();

    // One pop: head advances and dump is head-relative
    step(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 1'b0, 1'b0);
    view(2'd0, 2'd0, 5'd0);
    ex("c0_pop_head", S_DATA, 32'h22); ex("c0_pop_fill", S_FILL, 32'd2);
    ex("c0_pop_dmp0", S_DMPD, 32'h22);
    settle();

    // Fill ch1 to DEPTH
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 2'd1, 8'(8'h40 + i), 1'b0, 2'd0, 1'b0, 1'b0);
    end
    view(2'd1, 2'd1, 5'd31);
    ex("c1_full", S_FULL, 32'b010); ex("c1_fill32", S_FILL, 32'd32);
    ex("c1_empty_n", S_ENN, 32'b011); ex("c1_dmp31", S_DMPD, 32'h5F);
    ex("c1_ovf_clear", S_OVF, 32'h0);
    settle();

    // Overflowing push is discarded
    step(1'b1, 2'd1, 8'hEE, 1'b0, 2'd0, 1'b0, 1'b0);
    view(2'd1, 2'd1, 5'd31);
    ex("ovf_set", S_OVF, 32'b010); ex("ovf_fill", S_FILL, 32'd32);
    ex("ovf_dmp31", S_DMPD, 32'h5F);
    settle();

    // Push+pop on the full channel: both execute, no new flag
    step(1'b1, 2'd1, 8'h99, 1'b1, 2'd1, 1'b0, 1'b0);
    view(2'd1, 2'd1, 5'd31);
    ex("full_pp_fill", S_FILL, 32'd32); ex("full_pp_head", S_DATA, 32'h41);
    ex("full_pp_dmp31", S_DMPD, 32'h99); ex("full_pp_ovf", S_OVF, 32'b010);
    settle();
    step(1'b0, 2'd0, 8'h00, 1'b0, 2'd1, 1'b1, 1'b0);
    ex("clr_ovf", S_OVF, 32'h0);
    settle();
    step(1'b1, 2'd1, 8'hCC, 1'b0, 2'd1, 1'b1, 1'b0);
    ex("ovf_beats_clr", S_OVF, 32'b010); ex("ovf_beats_clr_dmp", S_DMPD, 32'h99);
    settle();
    step(1'b0, 2'd0, 8'h00, 1'b0, 2'd1, 1'b1, 1'b0);
    ex("clr_ovf2", S_OVF, 32'h0);
    settle();

    // Drain ch0 and underflow it
    step(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 1'b0, 1'b0);
    step(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 1'b0, 1'b0);
    view(2'd0, 2'd0, 5'd0);
    ex("c0_drained_fill", S_FILL, 32'd0); ex("c0_drained_data", S_DATA, 32'h0);
    ex("c0_drained_enn", S_ENN, 32'b010); ex("c0_drained_udf", S_UDF, 32'h0);
    settle();
    step(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 1'b0, 1'b0);
    view(2'd0, 2'd0, 5'd0);
    ex("udf_set", S_UDF, 32'b001); ex("udf_fill", S_FILL, 32'd0);
    ex("udf_enn", S_ENN, 32'b010);
    settle();
    step(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0);
    ex("clr_udf", S_UDF, 32'h0);
    settle();
    step(1'b1, 2'd0, 8'h77, 1'b1, 2'd0, 1'b0, 1'b0);
    view(2'd0, 2'd0, 5'd0);
    ex("empty_pp_fill", S_FILL, 32'd1); ex("empty_pp_udf", S_UDF, 32'b001);
    ex("empty_pp_data", S_DATA, 32'h77);
    settle();
    step(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 1'b0, 1'b0);
    ex("udf_sticky", S_UDF, 32'b001); ex("c0_empty_again", S_FILL, 32'd0);
    settle();

    // Push ch0 and pop ch1 in the same cycle
    step(1'b1, 2'd0, 8'hA1, 1'b1, 2'd1, 1'b0, 1'b0);
    view(2'd1, 2'd0, 5'd0);
    ex("xch_c0_fill", S_FILL, 32'd1); ex("xch_c1_head", S_DATA, 32'h42);
    ex("xch_full", S_FULL, 32'b000);
    settle();
    view(2'd0, 2'd1, 5'd0);
    ex("xch_c1_fill", S_FILL, 32'd31); ex("xch_c0_head", S_DATA, 32'hA1);
    settle();

    // 40 push/pop pairs on ch0 to wrap its pointers
    step(1'b1, 2'd0, 8'hB2, 1'b0, 2'd0, 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 2'd0, 8'(3 * k + 5), 1'b1, 2'd0, 1'b0, 1'b0);
      view(2'd0, 2'd0, 5'd1);
      ex("wrap_head", S_DATA, (k == 0) ? 32'hB2 : 32'(3 * (k - 1) + 5));
      ex("wrap_tail", S_DMPD, 32'(3 * k + 5));
      ex("wrap_fill", S_FILL, 32'd2);
      settle();
    end

    // Reset concurrent with a push while ch0 holds 5 words
    step(1'b1, 2'd0, 8'hD1, 1'b0, 2'd0, 1'b0, 1'b0);
    step(1'b1, 2'd0, 8'hD2, 1'b0, 2'd0, 1'b0, 1'b0);
    step(1'b1, 2'd0, 8'hD3, 1'b0, 2'd0, 1'b0, 1'b0);
    view(2'd0, 2'd0, 5'd4);
    ex("pre_rst_fill5", S_FILL, 32'd5); ex("pre_rst_dmp4", S_DMPD, 32'hD3);
    settle();
    step(1'b1, 2'd0, 8'hE0, 1'b0, 2'd0, 1'b0, 1'b1);
    view(2'd0, 2'd0, 5'd0);
    ex("mid_rst_enn", S_ENN, 32'h0); ex("mid_rst_full", S_FULL, 32'h0);
    ex("mid_rst_fill", S_FILL, 32'd0); ex("mid_rst_ovf", S_OVF, 32'h0);
    ex("mid_rst_udf", S_UDF, 32'h0); ex("mid_rst_data", S_DATA, 32'h0);
    ex("mid_rst_dmpv", S_DMPV, 32'h0);
    settle();
    view(2'd1, 2'd1, 5'd0);
    ex("mid_rst_c1_fill", S_FILL, 32'd0);
    settle();

    // Out-of-range channel selects
    step(1'b1, 2'd2, 8'h5A, 1'b0, 2'd0, 1'b0, 1'b0);
    step(1'b1, 2'd3, 8'h6B, 1'b1, 2'd3, 1'b0, 1'b0);
    view(2'd2, 2'd2, 5'd1);
    ex("bad_ch_enn", S_ENN, 32'b100); ex("bad_ch_udf", S_UDF, 32'h0);
    ex("bad_ch_ovf", S_OVF, 32'h0); ex("c2_fill", S_FILL, 32'd1);
    ex("c2_head", S_DATA, 32'h5A); ex("c2_dmp1_valid", S_DMPV, 32'h0);
    settle();
    view(2'd3, 2'd3, 5'd0);
    ex("bad_dmp_valid", S_DMPV, 32'h0); ex("bad_dmp_fill", S_FILL, 32'd0);
    ex("bad_dmp_data", S_DMPD, 32'h0); ex("bad_rd_data", S_DATA, 32'h0);
    settle();

    // Bounded drain of the scoreboard
    for (int t = 0; t < 10 && sb_q.size() > 0; t++) begin
      @(negedge clk); #1;
    end
    if (sb_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
